// File: rtl/gf4_mulxor_sqsc_pipe.sv
// gf4_mulxor_sqsc_pipe
// Masked GF(4) multiply-XOR-square-scale stage for the AES S-box datapath.
// The cross-share products form ta/tb. N_COPIES guarded and refreshed copies
// are registered, with even copies carrying ta and odd copies carrying tb.
// Each copy is then compressed to 2 bits. The stage registers hold whenever
// in_valid is low, so no transitional leakage occurs on idle cycles.
// Optional build macro: GF4MXS_OUT_REG_EN adds an output register on the
// compressed bits. This cuts the XOR glitch path and raises latency to 2.
module gf4_mulxor_sqsc_pipe #(
    parameter int N_COPIES = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [3:0]            share0,
    input  logic [3:0]            share1,
    input  logic [N_COPIES-1:0]   guards,
    input  logic [N_COPIES-1:0]   random,
    output logic                  out_valid,
    output logic [2*N_COPIES-1:0] out_shares,
    output logic [CNT_W-1:0]      op_cnt
);

    logic w_a0, w_b0, w_c0, w_d0, w_a1, w_b1, w_c1, w_d1;
    logic [3:0] w_ta, w_tb;
    logic [3:0] r_stage [N_COPIES];
    logic [2*N_COPIES-1:0] w_comp;
    logic r_v1;
    logic [CNT_W-1:0] r_op_cnt;

    assign {w_d0, w_c0, w_b0, w_a0} = share0;
    assign {w_d1, w_c1, w_b1, w_a1} = share1;

    // Nonlinear functions from the cross-share products (no input register)
    always_comb begin
        w_ta[0] = w_b0 ^ (w_a0 & w_c0) ^ (w_b0 & w_c0) ^ (w_a0 & w_d0);
        w_ta[1] = (w_a0 & w_c1) ^ (w_b0 & w_c1) ^ (w_a0 & w_d1);
        w_ta[2] = w_b1 ^ w_d0 ^ (w_a1 & w_c0) ^ (w_b1 & w_c0) ^ (w_a1 & w_d0);
        w_ta[3] = w_d1 ^ (w_a1 & w_c1) ^ (w_b1 & w_c1) ^ (w_a1 & w_d1);
        w_tb[0] = w_a0 ^ w_b0 ^ (w_b0 & w_c0) ^ (w_a0 & w_d0) ^ (w_b0 & w_d0);
        w_tb[1] = (w_b0 & w_c1) ^ (w_a0 & w_d1) ^ (w_b0 & w_d1);
        w_tb[2] = w_a1 ^ w_b1 ^ w_c0 ^ w_d0 ^ (w_b1 & w_c0) ^ (w_a1 & w_d0)
                  ^ (w_b1 & w_d0);
        w_tb[3] = w_c1 ^ w_d1 ^ (w_b1 & w_c1) ^ (w_a1 & w_d1) ^ (w_b1 & w_d1);
    end

    // Stage registers: load the guarded, refreshed copies only on accepted input
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_COPIES; k++) r_stage[k] <= 4'b0000;
        end else if (in_valid) begin
            for (int k = 0; k < N_COPIES; k++) begin
                if (k % 2 == 0) begin
                    r_stage[k] <= {w_ta[3] ^ guards[k],
                                   w_ta[2] ^ guards[k] ^ random[k],
                                   w_ta[1] ^ guards[k],
                                   w_ta[0] ^ guards[k] ^ random[k]};
                end else begin
                    r_stage[k] <= {w_tb[3] ^ guards[k],
                                   w_tb[2] ^ guards[k] ^ random[k],
                                   w_tb[1] ^ guards[k],
                                   w_tb[0] ^ guards[k] ^ random[k]};
                end
            end
        end
    end

    // Compression: the guards cancel pairwise, and the random bit remains as the mask
    always_comb begin
        w_comp = '0;
        for (int k = 0; k < N_COPIES; k++) begin
            w_comp[2*k]   = r_stage[k][0] ^ r_stage[k][1];
            w_comp[2*k+1] = r_stage[k][2] ^ r_stage[k][3];
        end
    end

    // Stage-1 valid and accepted-operation counter (wraps silently)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_op_cnt <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) r_op_cnt <= r_op_cnt + CNT_W'(1);
        end
    end

    assign op_cnt = r_op_cnt;

`ifdef GF4MXS_OUT_REG_EN
    logic [2*N_COPIES-1:0] r_out;
    logic r_v2;

    // Output register on the compressed bits, loaded only behind a valid stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) r_out <= w_comp;
        end
    end

    assign out_shares = r_out;
    assign out_valid  = r_v2;
`else
    assign out_shares = w_comp;
    assign out_valid  = r_v1;
`endif

endmodule
